udp_packetizer: RTL and testbench
=================================

UDP_PACKETIZER -- requirements
Module: udp_packetizer

Interface
REQ-001 Parameter DATA_W, default 256, width of one DRAM data word.
REQ-002 Parameter TX_W, default 8, Ethernet beat width; SHALL divide both 224 and DATA_W.
REQ-003 Parameter WORDS_PER_PKT, default 4, range 1..16, data words carried per packet.
REQ-004 Parameter FIFO_DEPTH, default 16, word buffer depth; SHALL be at least WORDS_PER_PKT.
REQ-005 Parameters SRC_IP = 32'hC0A80001, DST_IP = 32'hC0A80002, SRC_PORT = 16'h0000, DST_PORT = 16'h0001 give the header constants.
REQ-006 clk  input  1  sole clock; all logic is on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 in_data  input  DATA_W  data word from the DRAM read path.
REQ-009 in_valid  input  1  in_data is valid this cycle.
REQ-010 in_ready  output  1  FIFO not full.
REQ-011 tx_data  output  TX_W  Ethernet beat, MSB-first.
REQ-012 tx_valid  output  1  tx_data is valid.
REQ-013 tx_ready  input  1  sink accepts the beat.
REQ-014 tx_last  output  1  final beat of the packet.
REQ-015 pkt_count  output  16  count of completed packets; wraps.
REQ-016 overflow  output  1  sticky; set when a word is dropped.

Function
REQ-017 A word SHALL be written to the FIFO on in_valid && in_ready; a write and a read in the same cycle SHALL both take effect.
REQ-018 A word presented on in_valid while in_ready=0 SHALL be dropped and SHALL set overflow, which stays set until rst.
REQ-019 State machine states SHALL be IDLE, HEADER and PAYLOAD.
REQ-020 IDLE -> HEADER transition: at a clock edge where state=IDLE and FIFO count >= WORDS_PER_PKT, the block SHALL latch the 224-bit header and present its first beat with tx_valid=1 after that same edge.
REQ-021 A beat SHALL be accepted only on tx_valid && tx_ready; tx_data and tx_last SHALL be held stable while tx_valid=1 && tx_ready=0.
REQ-022 HEADER SHALL emit 224/TX_W beats, then move to PAYLOAD with no gap when tx_ready is held high.
REQ-023 PAYLOAD SHALL emit WORDS_PER_PKT*DATA_W/TX_W beats, taking each word MSB-first from the FIFO head; each word is popped when its last beat is accepted.
REQ-024 tx_last SHALL be 1 only on the final payload beat.
REQ-025 On acceptance of that final beat, the block SHALL go to IDLE, increment pkt_count and increment the sequence number.
REQ-026 tx_valid SHALL be 0 for at least one cycle between packets.
REQ-027 Header field order SHALL be: Version=4, IHL=5, DSCP/ECN=0, IP_Len, Identification, Flags=3'b010, FragOffset=0, TTL=64, Protocol=17, IP_Checksum, SRC_IP, DST_IP, SRC_PORT, DST_PORT, UDP_Len, UDP_Checksum=0.
REQ-028 Field values SHALL be: IP_Len = 28 + WORDS_PER_PKT*DATA_W/8; UDP_Len = 8 + WORDS_PER_PKT*DATA_W/8; Identification = 16-bit sequence number, 0 after reset, wrapping 16'hFFFF -> 0.
REQ-029 IP_Checksum SHALL be the ones-complement of the 16-bit ones-complement sum of the ten IP-header halfwords, with the checksum field taken as 0, all carries folded; it is computed for the current Identification.
REQ-030 FIFO empty during PAYLOAD cannot occur by REQ-020; the FIFO SHALL never underflow.
REQ-031 The header SHALL be latched at the IDLE exit; it SHALL be unaffected by sequence-number or input changes during the packet.

Reset
REQ-032 While rst=1 at an edge, the block SHALL set: tx_data=0, tx_valid=0, tx_last=0, pkt_count=0, overflow=0, sequence=0, FIFO emptied, state=IDLE, and in_ready=1 on the next cycle.
REQ-033 rst asserted mid-packet SHALL abort the packet immediately with no tx_last, and all buffered words SHALL be discarded.

Verification
REQ-034 Defaults, write 4 words, tx_ready=1 -> 156 contiguous beats; beat 2..3 = 0x00,0x9C; beat 10..11 = 0xB8,0xFD; beat 24..25 = 0x00,0x88; tx_last on beat 156; pkt_count=1.
REQ-035 Two packets back-to-back with 8 words preloaded -> second Identification=0x0001 and checksum=0xB8FC; at least one idle cycle between the packets.
REQ-036 Toggle tx_ready randomly 50% -> byte stream identical to REQ-034; tx_data stable during every stall.
REQ-037 Write 17 words with tx_ready=0 and no reads -> in_ready=0 after 16 words; word 17 dropped; overflow=1.
REQ-038 Write 3 words -> tx_valid stays 0; the 4th word starts the packet after the next edge.
REQ-039 Assert rst at payload beat 50 -> tx_valid=0 on the next cycle, pkt_count=0; a fresh 4 words give Identification=0x0000.

Source files
------------

// File: rtl/udp_packetizer.sv
// Buffers DRAM data words in a FIFO and emits them as IPv4/UDP packets,
// one TX_W-bit beat at a time, with a 224-bit header latched per packet.
module udp_packetizer #(
  parameter int unsigned DATA_W        = 256,
  parameter int unsigned TX_W          = 8,
  parameter int unsigned WORDS_PER_PKT = 4,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter logic [31:0] SRC_IP        = 32'hC0A80001,
  parameter logic [31:0] DST_IP        = 32'hC0A80002,
  parameter logic [15:0] SRC_PORT      = 16'h0000,
  parameter logic [15:0] DST_PORT      = 16'h0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [TX_W-1:0]   tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic [15:0]       pkt_count,
  output logic              overflow
);

  localparam int unsigned HDR_W      = 224;
  localparam int unsigned HDR_BEATS  = HDR_W / TX_W;
  localparam int unsigned WORD_BEATS = DATA_W / TX_W;
  localparam int unsigned MAX_BEATS  = (HDR_BEATS > WORD_BEATS) ? HDR_BEATS : WORD_BEATS;
  localparam int unsigned BW         = $clog2(MAX_BEATS + 1);
  localparam int unsigned PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW         = $clog2(DATA_W);
  localparam logic [15:0] IP_LEN     = 16'(28 + WORDS_PER_PKT * DATA_W / 8);
  localparam logic [15:0] UDP_LEN    = 16'(8 + WORDS_PER_PKT * DATA_W / 8);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t              state, state_nx;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                wr_en, pop, hdr_load, accept;
  logic [HDR_W-1:0]    hdr_sh;
  logic [BW-1:0]       beat_cnt;
  logic [4:0]          word_cnt;
  logic [15:0]         seq;
  logic                hdr_end, word_end, pkt_end;
  logic [DATA_W-1:0]   head_word;
  logic [SW-1:0]       pl_lsb;

  function automatic logic [15:0] ip_csum(input logic [15:0] id);
    logic [19:0] s;
    s = 20'h04500 + 20'(IP_LEN) + 20'(id) + 20'h04000 + 20'h04011
      + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0]) + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
    s = 20'(s[15:0]) + 20'(s[19:16]);
    s = 20'(s[15:0]) + 20'(s[19:16]);
    return ~s[15:0];
  endfunction

  function automatic logic [HDR_W-1:0] build_hdr(input logic [15:0] id);
    return {16'h4500, IP_LEN, id, 16'h4000, 16'h4011, ip_csum(id),
            SRC_IP, DST_IP, SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};
  endfunction

  assign in_ready = (count != CW'(FIFO_DEPTH));
  assign wr_en    = in_valid && in_ready;
  assign accept   = tx_valid && tx_ready;
  assign hdr_end  = (beat_cnt == BW'(HDR_BEATS - 1));
  assign word_end = (beat_cnt == BW'(WORD_BEATS - 1));
  assign pkt_end  = word_end && (word_cnt == 5'(WORDS_PER_PKT - 1));
  assign head_word = mem[rd_ptr];
  assign pl_lsb    = SW'(DATA_W - TX_W - TX_W * beat_cnt);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)   rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(pop);
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_last  = 1'b0;
    pop      = 1'b0;
    hdr_load = 1'b0;
    case (state)
      IDLE: begin
        if (count >= CW'(WORDS_PER_PKT)) begin
          hdr_load = 1'b1;
          state_nx = HEADER;
        end
      end
      HEADER: begin
        tx_valid = 1'b1;
        tx_data  = hdr_sh[HDR_W-1 -: TX_W];
        if (tx_ready && hdr_end) state_nx = PAYLOAD;
      end
      PAYLOAD: begin
        tx_valid = 1'b1;
        tx_data  = head_word[pl_lsb +: TX_W];
        tx_last  = pkt_end;
        pop      = tx_ready && word_end;
        if (tx_ready && pkt_end) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Header is snapshotted on IDLE exit, so seq may advance mid-packet safely.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_sh    <= '0;
      beat_cnt  <= '0;
      word_cnt  <= '0;
      seq       <= '0;
      pkt_count <= '0;
    end else begin
      if (hdr_load) begin
        hdr_sh   <= build_hdr(seq);
        beat_cnt <= '0;
        word_cnt <= '0;
      end else if (accept && state == HEADER) begin
        hdr_sh   <= hdr_sh << TX_W;
        beat_cnt <= hdr_end ? '0 : beat_cnt + 1'b1;
      end else if (accept && state == PAYLOAD) begin
        beat_cnt <= word_end ? '0 : beat_cnt + 1'b1;
        if (word_end) word_cnt <= word_cnt + 1'b1;
        if (pkt_end) begin
          seq       <= seq + 16'd1;
          pkt_count <= pkt_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_udp_packetizer.sv
// Directed bench for udp_packetizer: a byte-level packet model predicts the
// stream, FIFO occupancy, pkt_count and overflow; literals pin known headers.
module tb_udp_packetizer;

  localparam int PAY = 4 * 256 / 8;
  localparam int IPL = 28 + PAY;
  localparam int UL  = 8 + PAY;
  localparam int NB  = 28 + PAY;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_last;
  logic [15:0]  pkt_count;
  logic         overflow;

  udp_packetizer #(.DATA_W(256), .TX_W(8), .WORDS_PER_PKT(4), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .pkt_count(pkt_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] mk_word(input int i);
    logic [255:0] w;
    for (int j = 0; j < 32; j++) w[255-8*j -: 8] = 8'(i * 37 + j * 5 + 1);
    return w;
  endfunction

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       wend;
  } beat_t;

  beat_t        exp_q[$];
  logic [255:0] words_q[$];
  int           occ = 0, m_pkts = 0, cap_n = 0, pkts_seen = 0, cyc = 0;
  int           first_cyc = 0, span = 0;
  logic [15:0]  seq_m = 16'h0;
  bit           m_ovf = 0, seen_rst = 0, prev_last = 0, stalled = 0;
  logic [7:0]   st_d;
  logic         st_l;
  logic [7:0]   cap [NB];
  logic [7:0]   last_pkt [NB];
  logic [7:0]   ref_pkt [NB];

  task automatic build_packet();
    logic [7:0]   h [28];
    logic [31:0]  s;
    logic [15:0]  cs;
    logic [255:0] w;
    h = '{8'h45, 8'h00, 8'(IPL >> 8), 8'(IPL), seq_m[15:8], seq_m[7:0], 8'h40, 8'h00,
          8'd64, 8'd17, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'h02,
          8'h00, 8'h00, 8'h00, 8'h01, 8'(UL >> 8), 8'(UL), 8'h00, 8'h00};
    s = 0;
    for (int k = 0; k < 10; k++) s += {16'h0, h[2*k], h[2*k+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    cs = ~s[15:0];
    h[10] = cs[15:8];
    h[11] = cs[7:0];
    for (int k = 0; k < 28; k++) exp_q.push_back('{h[k], 1'b0, 1'b0});
    for (int i = 0; i < 4; i++) begin
      w = words_q.pop_front();
      for (int j = 0; j < 32; j++)
        exp_q.push_back('{w[255-8*j -: 8], (i == 3 && j == 31), (j == 31)});
    end
    seq_m = seq_m + 16'd1;
  endtask

  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (rst) begin
      seen_rst = 1; exp_q.delete(); words_q.delete();
      occ = 0; m_pkts = 0; seq_m = 16'h0; m_ovf = 0;
      prev_last = 0; stalled = 0; cap_n = 0;
    end else if (seen_rst) begin
      chk("in_ready", in_ready, occ < 16);
      chk("pkt_count", pkt_count, 16'(m_pkts));
      chk("overflow", overflow, m_ovf);
      if (prev_last) chk("idle_gap", tx_valid, 0);
      if (stalled) begin
        chk("stall_valid", tx_valid, 1);
        chk("stall_data", tx_data, st_d);
        chk("stall_last", tx_last, st_l);
      end
      prev_last = 0;
      stalled   = 0;
      if (tx_valid && tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=none t=%0t", tx_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", tx_data, e.d);
          chk("beat_last", tx_last, e.last);
          if (e.wend) occ--;
          if (cap_n == 0) first_cyc = cyc;
          if (cap_n < NB) cap[cap_n] = tx_data;
          cap_n++;
          if (e.last) begin
            m_pkts++;
            prev_last = 1;
            last_pkt  = cap;
            span      = cyc - first_cyc + 1;
            pkts_seen++;
            cap_n = 0;
          end
        end
      end else if (tx_valid) begin
        stalled = 1;
        st_d    = tx_data;
        st_l    = tx_last;
      end
      if (in_valid) begin
        if (occ < 16) begin
          occ++;
          words_q.push_back(in_data);
          if (words_q.size() == 4) build_packet();
        end else begin
          m_ovf = 1;
        end
      end
    end
  end

  task automatic put_word(input logic [255:0] w);
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_pkts(input int target, input int budget);
    int n = 0;
    while (pkts_seen < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pkt_timeout", pkts_seen >= target, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int base, n, d;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_last", tx_last, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_in_ready", in_ready, 1);

    // Single packet, sink always ready
    tx_ready = 1'b1;
    base = pkts_seen;
    for (int i = 0; i < 4; i++) put_word(mk_word(i));
    wait_pkts(base + 1, 400);
    chk("p1_b2", last_pkt[2], 8'h00);
    chk("p1_b3", last_pkt[3], 8'h9C);
    chk("p1_b10", last_pkt[10], 8'hB8);
    chk("p1_b11", last_pkt[11], 8'hFD);
    chk("p1_b24", last_pkt[24], 8'h00);
    chk("p1_b25", last_pkt[25], 8'h88);
    chk("p1_span", span, 156);
    chk("p1_pkt_count", pkt_count, 1);
    ref_pkt = last_pkt;

    // Three words must not start a packet; the fourth starts it one edge later
    for (int i = 4; i < 7; i++) put_word(mk_word(i));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("three_words_idle", tx_valid, 0);
    end
    base = pkts_seen;
    put_word(mk_word(7));
    chk("fourth_word_edge0", tx_valid, 0);
    @(posedge clk); #1;
    chk("fourth_word_edge1", tx_valid, 1);
    wait_pkts(base + 1, 400);
    chk("p2_id_lo", last_pkt[5], 8'h01);

    // Two back-to-back packets from 8 preloaded words
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) put_word(mk_word(i));
    base = pkts_seen;
    tx_ready = 1'b1;
    wait_pkts(base + 2, 800);
    chk("b2b_id_hi", last_pkt[4], 8'h00);
    chk("b2b_id_lo", last_pkt[5], 8'h01);
    chk("b2b_cs_hi", last_pkt[10], 8'hB8);
    chk("b2b_cs_lo", last_pkt[11], 8'hFC);
    chk("b2b_pkt_count", pkt_count, 2);

    // Random backpressure must reproduce the first packet byte for byte
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) put_word(mk_word(i));
    base = pkts_seen;
    n = 0;
    while (pkts_seen < base + 1 && n < 3000) begin
      tx_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    chk("bp_timeout", pkts_seen >= base + 1, 1);
    tx_ready = 1'b1;
    d = 0;
    for (int k = 0; k < NB; k++) if (last_pkt[k] !== ref_pkt[k]) d++;
    chk("bp_stream_diff", d, 0);

    // FIFO fill with no reads: 16 accepted, 17th dropped
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_data  = mk_word(i + 10);
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (i == 15) begin
        chk("full_in_ready", in_ready, 0);
        chk("full_no_ovf_yet", overflow, 0);
      end
    end
    in_valid = 1'b0;
    chk("drop_overflow", overflow, 1);
    repeat (5) @(posedge clk);
    #1 chk("overflow_sticky", overflow, 1);

    // Reset at payload beat 50 aborts the packet
    do_reset();
    chk("rst_clears_ovf", overflow, 0);
    tx_ready = 1'b1;
    base = pkts_seen;
    for (int i = 0; i < 4; i++) put_word(mk_word(i + 40));
    n = 0;
    while (cap_n < 78 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_beat78", cap_n, 78);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_tx_last", tx_last, 0);
    chk("abort_pkt_count", pkt_count, 0);
    chk("abort_no_pkt", pkts_seen, base);
    for (int i = 0; i < 4; i++) put_word(mk_word(i + 50));
    wait_pkts(base + 1, 400);
    chk("fresh_id_hi", last_pkt[4], 8'h00);
    chk("fresh_id_lo", last_pkt[5], 8'h00);
    chk("fresh_cs_hi", last_pkt[10], 8'hB8);
    chk("fresh_cs_lo", last_pkt[11], 8'hFD);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
